fsm_result_packer: RTL

Downstream stage of the control FSM. Consumes the FSM's per-cycle byte results and its done pulse, packs bytes into 32-bit words with byte-keep masks, and appends a frame checksum on the last word. Words are buffered in a small FIFO and drained through a valid/ready interface toward the bus/DMA side. It also keeps a saturating count of completed frames.

---
 rtl/fsm_pkg.sv | 25 ++
 rtl/fsm_word_fifo.sv | 56 +++++
 rtl/fsm_result_packer.sv | 92 +++++++++
 3 files changed

// File: rtl/fsm_pkg.sv
// fsm_pkg: shared widths, packed-word FIFO entry and helpers for the FSM result path
package fsm_pkg;

    localparam int KEEP_W = 4;
    localparam int LANE_W = 2;
    localparam int CHK_W  = 8;

    // Error code the FSM may emit as a result byte; packed like any other data here
    localparam logic [7:0] FSM_ERR_CODE = 8'hEE;

    typedef struct packed {
        logic [31:0]       data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic [CHK_W-1:0]  chk;
    } word_entry_t;

    // Contiguous keep mask covering lanes 0..lane
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [LANE_W-1:0] lane);
        logic [KEEP_W-1:0] ones;
        ones = '1;
        return ones >> (2'd3 - lane);
    endfunction

endpackage

// File: rtl/fsm_word_fifo.sv
// fsm_word_fifo: synchronous FIFO of packed result words with flush
module fsm_word_fifo
    import fsm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  word_entry_t              push_entry,
    input  logic                     pop,
    output word_entry_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    word_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over any same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop) count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    // Entry storage; contents are only visible through head while non-empty
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fsm_result_packer.sv
// fsm_result_packer: packs FSM result bytes into keep-masked 32-bit words with frame checksum
module fsm_result_packer
    import fsm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             soft_clr,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_keep,
    output logic             out_last,
    output logic [7:0]       out_chk,
    output logic [CNT_W-1:0] frame_cnt
);

    logic [LANE_W-1:0]          lane_cnt;
    logic [31:0]                partial;
    logic [CHK_W-1:0]           chk;
    logic [CHK_W-1:0]           chk_next;
    logic [31:0]                cur_word;
    logic                       accept;
    logic                       complete;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic [$clog2(FIFO_DEPTH):0] count;
    word_entry_t                push_entry;
    word_entry_t                head;

    assign in_ready  = ~full;
    assign accept    = in_valid & in_ready;
    assign complete  = accept & ((lane_cnt == 2'd3) | in_last);
    assign chk_next  = chk ^ in_data;
    assign cur_word  = partial | ({24'h0, in_data} << {lane_cnt, 3'b000});
    assign push      = complete & ~soft_clr;
    assign pop       = out_valid & out_ready & ~soft_clr;

    assign push_entry = '{data: cur_word, keep: keep_mask(lane_cnt), last: in_last,
                          chk: in_last ? chk_next : '0};

    assign out_valid = ~empty;
    assign out_data  = head.data;
    assign out_keep  = head.keep;
    assign out_last  = head.last;
    assign out_chk   = head.chk;

    fsm_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (soft_clr),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    // Lane packing and running checksum; a completed word restarts the lane, a frame end restarts the checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt <= '0;
            partial  <= '0;
            chk      <= '0;
        end else if (soft_clr) begin
            lane_cnt <= '0;
            partial  <= '0;
            chk      <= '0;
        end else if (accept) begin
            lane_cnt <= complete ? '0 : lane_cnt + LANE_W'(1);
            partial  <= complete ? '0 : cur_word;
            chk      <= in_last ? '0 : chk_next;
        end
    end

    // Saturating count of frames whose closing word entered the FIFO; survives soft_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt <= '0;
        else if (push && in_last && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
    end

endmodule
